// File: rtl/z80_bus_fabric_pkg.sv
// ============================================================================
// Module   : nanoz80_bus_pkg
// Brief    : Shared types and constants for the Z80 bus fabric.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package nanoz80_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } bus_state_t;

    typedef enum logic [1:0] {
        ACC_MEM      = 2'd0,
        ACC_SLOT     = 2'd1,
        ACC_CTRL     = 2'd2,
        ACC_UNMAPPED = 2'd3
    } access_kind_t;

    localparam logic [3:0] CTRL_NIBBLE   = 4'hF;
    localparam logic [3:0] REG_PAGE0     = 4'h0;
    localparam logic [3:0] REG_PAGE3     = 4'h3;
    localparam logic [3:0] REG_CTRL      = 4'h4;
    localparam logic [3:0] REG_STATUS    = 4'h5;
    localparam logic [7:0] UNMAPPED_DATA = 8'hFF;

endpackage

`default_nettype wire

// File: rtl/z80_bus_fabric_bank_regs.sv
// ============================================================================
// Module   : z80_bank_regs
// Brief    : Page registers, ROM/wait control and sticky status with readback.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module z80_bank_regs
    import nanoz80_bus_pkg::*;
#(
    parameter int PHYS_BANK_BITS = 4,
    parameter int MEM_WAIT_RESET = 0
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           wr_en,
    input  logic [3:0]                     reg_offset,
    input  logic [7:0]                     wr_data,
    input  logic                           set_timeout,
    output logic [7:0]                     rd_data,
    output logic [3:0][PHYS_BANK_BITS-1:0] page,
    output logic                           rom_en,
    output logic [2:0]                     mem_wait
);

    logic timeout_flag;
    logic unused_wr_bits;

    assign unused_wr_bits = ^wr_data;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < 4; i++) begin
                page[i] <= PHYS_BANK_BITS'(i);
            end
            rom_en       <= 1'b1;
            mem_wait     <= 3'(MEM_WAIT_RESET);
            timeout_flag <= 1'b0;
        end else begin
            if (wr_en && reg_offset[3:2] == 2'b00) begin
                page[reg_offset[1:0]] <= wr_data[PHYS_BANK_BITS-1:0];
            end
            if (wr_en && reg_offset == REG_CTRL) begin
                rom_en   <= wr_data[0];
                mem_wait <= wr_data[3:1];
            end
            // A timeout arriving in the same cycle as a clear must not be lost.
            if (set_timeout) begin
                timeout_flag <= 1'b1;
            end else if (wr_en && reg_offset == REG_STATUS && wr_data[0]) begin
                timeout_flag <= 1'b0;
            end
        end
    end

    always_comb begin
        rd_data = UNMAPPED_DATA;
        if (reg_offset[3:2] == 2'b00) begin
            rd_data                      = '0;
            rd_data[PHYS_BANK_BITS-1:0]  = page[reg_offset[1:0]];
        end else if (reg_offset == REG_CTRL) begin
            rd_data = {4'b0000, mem_wait, rom_en};
        end else if (reg_offset == REG_STATUS) begin
            rd_data = {7'b0000000, timeout_flag};
        end
    end

endmodule

`default_nettype wire

// File: rtl/z80_bus_fabric.sv
// ============================================================================
// Module   : z80_bus_fabric
// Brief    : Z80 chip-select decode, 16K paging, ROM overlay and wait-state FSM.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module z80_bus_fabric
    import nanoz80_bus_pkg::*;
#(
    parameter int N_IO_SLOTS     = 8,
    parameter int PHYS_BANK_BITS = 4,
    parameter int ROM_ADDR_BITS  = 13,
    parameter int MEM_WAIT_RESET = 0,
    parameter int IO_TIMEOUT     = 255
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         mreq_n,
    input  logic                         ioreq_n,
    input  logic                         rd_n,
    input  logic                         wr_n,
    input  logic [15:0]                  addr_i,
    input  logic [7:0]                   cpu_dout_i,
    output logic [7:0]                   cpu_di_o,
    output logic                         wait_n_o,
    output logic [PHYS_BANK_BITS+13:0]   phys_addr_o,
    output logic                         rom_cs_o,
    output logic                         ram_cs_o,
    output logic [N_IO_SLOTS-1:0]        io_cs_o,
    input  logic [7:0]                   rom_data_i,
    input  logic [7:0]                   ram_data_i,
    input  logic [8*N_IO_SLOTS-1:0]      io_data_i,
    input  logic [N_IO_SLOTS-1:0]        io_ready_i
);

    localparam int CNT_BITS = ($clog2(IO_TIMEOUT + 1) > 4) ? $clog2(IO_TIMEOUT + 1) : 4;

    bus_state_t    state;
    bus_state_t    state_next;
    access_kind_t  kind;
    access_kind_t  kind_decode;
    logic [3:0]    slot;
    logic          use_rom;
    logic          is_read;
    logic          wr_seen;
    logic [CNT_BITS-1:0] cnt;

    logic [3:0][PHYS_BANK_BITS-1:0] page;
    logic          rom_en;
    logic [2:0]    mem_wait;
    logic [7:0]    ctrl_rd_data;

    logic [3:0]    io_nibble;
    logic          mem_sel;
    logic          io_sel;
    logic          strobe;
    logic          in_rom_window;
    logic          slot_hit;
    logic          ctrl_hit;
    logic          ctrl_wr;
    logic          ready_hit;
    logic [7:0]    slot_data;
    logic          cnt_last;
    logic          set_timeout;

    assign io_nibble     = addr_i[7:4];
    assign mem_sel       = !mreq_n;
    assign io_sel        = !ioreq_n && mreq_n;
    assign strobe        = (mem_sel || io_sel) && (!rd_n || !wr_n);
    assign in_rom_window = (addr_i >> ROM_ADDR_BITS) == 16'd0;
    assign slot_hit      = io_sel && (32'(io_nibble) < N_IO_SLOTS);
    assign ctrl_hit      = io_sel && (io_nibble == CTRL_NIBBLE);
    // One commit per bus cycle even though wr_n stays low for several clocks.
    assign ctrl_wr       = ctrl_hit && !wr_n && !wr_seen;
    assign cnt_last      = (cnt == CNT_BITS'(1));
    assign set_timeout   = (state == ST_WAIT) && (kind == ACC_SLOT) && !ready_hit && cnt_last;
    assign phys_addr_o   = {page[addr_i[15:14]], addr_i[13:0]};

    z80_bank_regs #(
        .PHYS_BANK_BITS (PHYS_BANK_BITS),
        .MEM_WAIT_RESET (MEM_WAIT_RESET)
    ) u_bank_regs (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .wr_en       (ctrl_wr),
        .reg_offset  (addr_i[3:0]),
        .wr_data     (cpu_dout_i),
        .set_timeout (set_timeout),
        .rd_data     (ctrl_rd_data),
        .page        (page),
        .rom_en      (rom_en),
        .mem_wait    (mem_wait)
    );

    always_comb begin
        rom_cs_o = 1'b0;
        ram_cs_o = 1'b0;
        io_cs_o  = '0;
        if (!rst_i) begin
            // Writes into the ROM window fall through to RAM for shadow fill.
            if (mem_sel && rom_en && !rd_n && in_rom_window) begin
                rom_cs_o = 1'b1;
            end else if (mem_sel) begin
                ram_cs_o = 1'b1;
            end
            for (int k = 0; k < N_IO_SLOTS; k++) begin
                io_cs_o[k] = slot_hit && (io_nibble == 4'(k));
            end
        end
    end

    always_comb begin
        if (mem_sel) begin
            kind_decode = ACC_MEM;
        end else if (slot_hit) begin
            kind_decode = ACC_SLOT;
        end else if (ctrl_hit) begin
            kind_decode = ACC_CTRL;
        end else begin
            kind_decode = ACC_UNMAPPED;
        end
    end

    always_comb begin
        slot_data = UNMAPPED_DATA;
        ready_hit = 1'b0;
        for (int k = 0; k < N_IO_SLOTS; k++) begin
            if (slot == 4'(k)) begin
                slot_data = io_data_i[8*k +: 8];
                ready_hit = io_ready_i[k];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (strobe) begin
                    if (kind_decode == ACC_MEM || kind_decode == ACC_SLOT) begin
                        state_next = ST_WAIT;
                    end else begin
                        state_next = ST_DONE;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_last || (kind == ACC_SLOT && ready_hit)) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (mreq_n && ioreq_n) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        wait_n_o = (state != ST_WAIT);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            kind     <= ACC_MEM;
            slot     <= 4'd0;
            use_rom  <= 1'b0;
            is_read  <= 1'b0;
            wr_seen  <= 1'b0;
            cnt      <= '0;
            cpu_di_o <= UNMAPPED_DATA;
        end else begin
            if (mreq_n && ioreq_n) begin
                wr_seen <= 1'b0;
            end else if (ctrl_wr) begin
                wr_seen <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (strobe) begin
                        kind    <= kind_decode;
                        slot    <= io_nibble;
                        use_rom <= rom_cs_o;
                        is_read <= !rd_n;
                        if (kind_decode == ACC_MEM) begin
                            cnt <= CNT_BITS'(1) + CNT_BITS'(mem_wait);
                        end else begin
                            cnt <= CNT_BITS'(IO_TIMEOUT);
                        end
                        if (!rd_n && kind_decode == ACC_CTRL) begin
                            cpu_di_o <= ctrl_rd_data;
                        end else if (!rd_n && kind_decode == ACC_UNMAPPED) begin
                            cpu_di_o <= UNMAPPED_DATA;
                        end
                    end
                end
                ST_WAIT: begin
                    cnt <= cnt - CNT_BITS'(1);
                    if (kind == ACC_MEM) begin
                        if (cnt_last && is_read) begin
                            cpu_di_o <= use_rom ? rom_data_i : ram_data_i;
                        end
                    end else if (ready_hit) begin
                        if (is_read) begin
                            cpu_di_o <= slot_data;
                        end
                    end else if (cnt_last) begin
                        cpu_di_o <= UNMAPPED_DATA;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire
